btn_debounce_pulser: RTL and testbench
======================================

Name: btn_debounce_pulser

Overview:
- Push-button conditioning stage that sits directly upstream of the GCD PicoBlaze top.
- One instance per button (BtnL, BtnR, BtnU). It converts a raw, bouncy push-button into:
  - a debounced level (DPB);
  - a single-clock enable pulse (SCEN);
  - a repeating multi-clock enable (MCEN);
  - a continuous enable (CCEN).
- SCEN feeds the Start/Ack, in_AB and single-step pulse registers that the PicoBlaze handshake clears.

Parameters:
- CNT_W, 26: debounce/repeat counter width. Must satisfy 2^CNT_W > max(DB_CYCLES, MC_CYCLES).
- DB_CYCLES, 1000000: consecutive stable samples required to accept a press or a release (10 ms at 100 MHz).
- MC_CYCLES, 50000000: hold time before the first auto-repeat, and the repeat period after it (0.5 s).

Ports:
- board_clk  in  1  system clock, 100 MHz, all logic on its rising edge
- Reset  in  1  asynchronous, active-high reset
- PB  in  1  raw push-button level, active-high, asynchronous to board_clk
- DPB  out  1  debounced button level
- SCEN  out  1  single-clock enable: exactly one 1-cycle pulse per accepted press
- MCEN  out  1  multi-clock enable: 1-cycle pulses, first at press, then every MC_CYCLES while held
- CCEN  out  1  continuous enable: high every cycle once held past MC_CYCLES

Behaviour:
- Interface: reset Reset, asynchronous, active-high; clock board_clk.
- Reset state:
  - state=INI, count=0.
  - DPB=SCEN=MCEN=CCEN=0.
  - Reset asserted mid-press returns to INI immediately. After release of Reset, a still-held PB must be re-qualified through WQ; no pulse is issued on the Reset edge itself.
- Outputs are decoded from the registered state only. There is no combinational path PB->outputs.
- State register is 3 bits, 6 states:
  - INI: all outputs 0. PB=1 -> WQ with count=0.
  - WQ (wait quiet press): outputs 0.
    - PB=0 -> INI.
    - Else count++. When count==DB_CYCLES-1 with PB=1 -> SCEN_ST.
  - SCEN_ST: one cycle. SCEN=MCEN=CCEN=DPB=1. count<=0. -> MCW.
  - MCW (wait multi-clock): DPB=1, other outputs 0.
    - PB=0 -> WR, count<=0.
    - Else count++. When count==MC_CYCLES-1 -> MC_ST, count<=0.
  - MC_ST (continuous repeat): DPB=1, CCEN=1 every cycle. MCEN=1 only in the cycle where count==0.
    - count wraps MC_CYCLES-1 -> 0.
    - PB=0 -> WR, count<=0.
  - WR (wait release): DPB=1, other outputs 0.
    - PB=1 -> count<=0, stay in WR.
    - PB=0 -> count++. When count==DB_CYCLES-1 with PB=0 -> INI.
- Latency:
  - SCEN is high in the clock cycle beginning DB_CYCLES+1 edges after the first edge at which PB is sampled 1, provided PB stays 1 throughout.
  - DPB falls DB_CYCLES+1 edges after the first sampled 0 of a stable release.
- Bounce: any PB=0 sample during WQ aborts to INI with no output activity. Any PB=1 during WR restarts the release count.
- Exactly one SCEN per press/release cycle, regardless of hold length.
- Counter comparisons use CNT_W-bit unsigned equality. The counter never exceeds max(DB_CYCLES, MC_CYCLES)-1.

Optional Feature:
- Macro: BTN_DEBOUNCE_SYNC2_EN.
- Defined:
  - PB passes through a 2-flop synchronizer clocked by board_clk. Both flops reset to 0 by Reset.
  - The FSM samples the second flop. All latencies above increase by exactly 2 cycles.
- Undefined:
  - The FSM samples PB directly. The integrator guarantees PB is already synchronous.

Test Plan (bench parameters DB_CYCLES=4, MC_CYCLES=8, CNT_W=4, macro undefined):
- Clean press: PB 0->1 sampled at edge 0, held for 6 cycles -> SCEN=MCEN=CCEN=1 for exactly one cycle after edge 5; DPB=1 from edge 5.
- Bounce: PB=1 for 3 cycles, 0 for 1 cycle, then 1 for 3 cycles -> no SCEN at all; state returns to INI at the glitch.
- Long hold: PB held 40 cycles -> one SCEN; MCEN pulses at the SCEN cycle, then when MC_ST is entered, then every 8 cycles; CCEN continuous from MC_ST entry.
- Release with bounce: in MCW, PB goes 0,0,1,0,0,0,0 -> WR count restarts at the 1; DPB falls only after 4 consecutive 0 samples; no extra SCEN.
- Reset mid-hold: assert Reset in MC_ST with PB held -> all outputs 0 asynchronously; after deassert with PB still 1, SCEN again DB_CYCLES+1 edges later.
- With BTN_DEBOUNCE_SYNC2_EN defined, repeat the clean-press case -> SCEN after edge 7.

Source files
------------

// File: rtl/btn_debounce_pulser.sv
// btn_debounce_pulser
// Push-button conditioner: turns a raw, bouncy button level into a debounced
// level (DPB), a single-clock enable (SCEN), an auto-repeating multi-clock
// enable (MCEN) and a continuous enable once held (CCEN).
//
// Optional feature macro: BTN_DEBOUNCE_SYNC2_EN
//   defined   -> PB is passed through a 2-flop synchronizer before the FSM
//                (all latencies grow by 2 cycles)
//   undefined -> PB is sampled directly and must already be synchronous
//
// Outputs come from flops loaded with a decode of the registered state and
// counter, so PB never reaches an output combinationally. That output stage
// is what puts SCEN DB_CYCLES+1 edges after the first sampled press.

module btn_debounce_pulser #(
    parameter int unsigned CNT_W     = 26,
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned MC_CYCLES = 50000000
) (
    input  logic board_clk,
    input  logic Reset,
    input  logic PB,
    output logic DPB,
    output logic SCEN,
    output logic MCEN,
    output logic CCEN
);

    typedef enum logic [2:0] {
        INI     = 3'd0,
        WQ      = 3'd1,
        SCEN_ST = 3'd2,
        MCW     = 3'd3,
        MC_ST   = 3'd4,
        WR      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] MC_LAST = CNT_W'(MC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    logic w_pb;

    logic w_dpb;
    logic w_scen;
    logic w_mcen;
    logic w_ccen;

    logic r_dpb;
    logic r_scen;
    logic r_mcen;
    logic r_ccen;

`ifdef BTN_DEBOUNCE_SYNC2_EN
    logic r_pb_meta;
    logic r_pb_sync;

    // Two-stage synchronizer for the asynchronous button input
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_pb_meta <= 1'b0;
            r_pb_sync <= 1'b0;
        end else begin
            r_pb_meta <= PB;
            r_pb_sync <= r_pb_meta;
        end
    end

    assign w_pb = r_pb_sync;
`else
    assign w_pb = PB;
`endif

    // State and counter registers
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_state <= INI;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state and counter update: press qualify, hold/repeat, release qualify
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            INI: begin
                if (w_pb) begin
                    w_state_nxt = WQ;
                    w_count_nxt = '0;
                end
            end
            WQ: begin
                if (!w_pb) begin
                    w_state_nxt = INI;
                    w_count_nxt = '0;
                end else if (r_count == DB_LAST) begin
                    w_state_nxt = SCEN_ST;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + CNT_ONE;
                end
            end
            SCEN_ST: begin
                w_state_nxt = MCW;
                w_count_nxt = '0;
            end
            MCW: begin
                if (!w_pb) begin
                    w_state_nxt = WR;
                    w_count_nxt = '0;
                end else if (r_count == MC_LAST) begin
                    w_state_nxt = MC_ST;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + CNT_ONE;
                end
            end
            MC_ST: begin
                if (!w_pb) begin
                    w_state_nxt = WR;
                    w_count_nxt = '0;
                end else if (r_count == MC_LAST) begin
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + CNT_ONE;
                end
            end
            WR: begin
                if (w_pb) begin
                    w_count_nxt = '0;
                end else if (r_count == DB_LAST) begin
                    w_state_nxt = INI;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = INI;
                w_count_nxt = '0;
            end
        endcase
    end

    // Output decode from the registered state and counter only
    always_comb begin
        w_dpb  = 1'b0;
        w_scen = 1'b0;
        w_mcen = 1'b0;
        w_ccen = 1'b0;
        case (r_state)
            SCEN_ST: begin
                w_dpb  = 1'b1;
                w_scen = 1'b1;
                w_mcen = 1'b1;
                w_ccen = 1'b1;
            end
            MCW, WR: begin
                w_dpb = 1'b1;
            end
            MC_ST: begin
                w_dpb  = 1'b1;
                w_ccen = 1'b1;
                w_mcen = (r_count == '0);
            end
            default: begin
            end
        endcase
    end

    // Output flops, cleared asynchronously together with the FSM
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_dpb  <= 1'b0;
            r_scen <= 1'b0;
            r_mcen <= 1'b0;
            r_ccen <= 1'b0;
        end else begin
            r_dpb  <= w_dpb;
            r_scen <= w_scen;
            r_mcen <= w_mcen;
            r_ccen <= w_ccen;
        end
    end

    assign DPB  = r_dpb;
    assign SCEN = r_scen;
    assign MCEN = r_mcen;
    assign CCEN = r_ccen;

endmodule

// File: tb/tb_btn_debounce_pulser.sv
// Bench for btn_debounce_pulser (DB_CYCLES=4, MC_CYCLES=8, CNT_W=4).
// A run-length based model predicts {DPB,SCEN,MCEN,CCEN} every cycle; a few
// hand-computed edge numbers and pulse counts pin that model down.

module tb_btn_debounce_pulser;

    localparam int DB = 4;
    localparam int MC = 8;
`ifdef BTN_DEBOUNCE_SYNC2_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic board_clk;
    logic Reset;
    logic PB;
    logic DPB;
    logic SCEN;
    logic MCEN;
    logic CCEN;

    btn_debounce_pulser #(
        .CNT_W    (4),
        .DB_CYCLES(DB),
        .MC_CYCLES(MC)
    ) dut (
        .board_clk(board_clk),
        .Reset    (Reset),
        .PB       (PB),
        .DPB      (DPB),
        .SCEN     (SCEN),
        .MCEN     (MCEN),
        .CCEN     (CCEN)
    );

    initial board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    int checks   = 0;
    int failures = 0;

    // Edge counter and observed-event bookkeeping (written by compare process)
    int cyc        = 0;
    int scen_hits  = 0;
    int scen_last  = -1;
    int mcen_hits  = 0;
    int mcen_last  = -1;
    int ccen_hits  = 0;
    int dpb_rises  = 0;
    int dpb_fall   = -1;
    bit dpb_prev   = 1'b0;

    // Model state
    logic [3:0] pending = 4'b0000;  // expected {DPB,SCEN,MCEN,CCEN} after next edge
    bit  pressed = 1'b0;
    int  ones    = 0;
    int  t_acc   = 0;
    bit  rel     = 1'b0;
    int  z       = 0;
    int  thr     = 0;
    int  h       = 0;
    bit  dl1     = 1'b0;
    bit  dl2     = 1'b0;

    // Per-cycle compare against the model, then advance the model
    always begin
        logic       smp;
        logic       rst;
        logic       p;
        logic [3:0] got;
        @(posedge board_clk);
        cyc++;
        smp = PB;
        rst = Reset;
        #1;
        if (rst) pending = 4'b0000;
        got = {DPB, SCEN, MCEN, CCEN};
        checks++;
        if (got !== pending) begin
            failures++;
            $display("FAIL outputs cyc=%0d got=%b expected=%b", cyc, got, pending);
        end
        if (SCEN) begin scen_hits++; scen_last = cyc; end
        if (MCEN) begin mcen_hits++; mcen_last = cyc; end
        if (CCEN) ccen_hits++;
        if (DPB && !dpb_prev) dpb_rises++;
        if (!DPB && dpb_prev) dpb_fall = cyc;
        dpb_prev = DPB;

        if (rst) begin
            pressed = 1'b0; ones = 0; rel = 1'b0; z = 0;
            dl1 = 1'b0; dl2 = 1'b0;
        end else begin
            if (SL == 2) begin
                p = dl2; dl2 = dl1; dl1 = smp;
            end else begin
                p = smp;
            end
            if (!pressed) begin
                ones = p ? ones + 1 : 0;
                if (ones == DB + 1) begin
                    pressed = 1'b1; t_acc = cyc; rel = 1'b0; z = 0;
                    pending = 4'b1111;
                end else begin
                    pending = 4'b0000;
                end
            end else if (cyc == t_acc + 1) begin
                pending = 4'b1000;
            end else begin
                if (!rel) begin
                    if (!p) begin rel = 1'b1; z = 1; thr = DB + 1; end
                end else if (p) begin
                    z = 0; thr = DB;
                end else begin
                    z++;
                end
                if (rel && z == thr) begin
                    pressed = 1'b0; ones = 0; rel = 1'b0;
                    pending = 4'b0000;
                end else if (rel) begin
                    pending = 4'b1000;
                end else begin
                    h = cyc - (t_acc + 1);
                    if (h >= MC) pending = {1'b1, 1'b0, ((h - MC) % MC == 0), 1'b1};
                    else         pending = 4'b1000;
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge board_clk);
            PB = v;
        end
    endtask

    task automatic press_start(output int e);
        @(negedge board_clk);
        PB = 1'b1;
        e = cyc + 1;
    endtask

    initial begin
        int e0;
        int r0;
        int s0;
        int m0;
        int c0;
        int d0;

        Reset = 1'b1;
        PB    = 1'b0;
        drive(0, 3);
        chk("reset_outputs", int'({DPB, SCEN, MCEN, CCEN}), 0);
        @(negedge board_clk);
        Reset = 1'b0;
        drive(0, 4);

        // Clean press: six samples high
        s0 = scen_hits;
        press_start(e0);
        drive(1, 5);
        drive(0, 12);
        chk("clean_scen_edge", scen_last, e0 + 5 + SL);
        chk("clean_scen_count", scen_hits - s0, 1);
        chk("clean_dpb_fall", dpb_fall, e0 + 11 + SL);

        // Bounce during qualification
        s0 = scen_hits;
        d0 = dpb_rises;
        drive(1, 3);
        drive(0, 1);
        drive(1, 3);
        drive(0, 10);
        chk("bounce_scen_count", scen_hits - s0, 0);
        chk("bounce_dpb_rises", dpb_rises - d0, 0);

        // Long hold: 40 samples high
        s0 = scen_hits;
        m0 = mcen_hits;
        c0 = ccen_hits;
        press_start(e0);
        drive(1, 39);
        drive(0, 12);
        chk("hold_scen_count", scen_hits - s0, 1);
        chk("hold_mcen_count", mcen_hits - m0, 5);
        chk("hold_mcen_last", mcen_last, e0 + 38 + SL);
        chk("hold_ccen_count", ccen_hits - c0, 28);

        // Release with a bounce while waiting in MCW
        s0 = scen_hits;
        press_start(e0);
        drive(1, 6);
        drive(0, 2);
        drive(1, 1);
        drive(0, 12);
        chk("relb_scen_count", scen_hits - s0, 1);
        chk("relb_dpb_fall", dpb_fall, e0 + 14 + SL);

        // Reset asserted while repeating, button kept held
        s0 = scen_hits;
        press_start(e0);
        drive(1, 18);
        @(negedge board_clk);
        chk("pre_reset_outputs", int'({DPB, SCEN, MCEN, CCEN}), 9);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_reset_outputs", int'({DPB, SCEN, MCEN, CCEN}), 0);
        @(negedge board_clk);
        Reset = 1'b0;
        r0 = cyc + 1;
        drive(1, 10);
        drive(0, 12);
        chk("rehold_scen_edge", scen_last, r0 + 5 + SL);
        chk("rehold_scen_count", scen_hits - s0, 2);

        drive(0, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
